mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter and sequencer for a single shared, fixed-latency, word-addressed memory. It sits between the pipeline's fetch stage (read-only port I) and memory stage (read/write port D), and replaces the two independent `memory2c` instances when the processor moves to a unified multi-cycle memory. It owns the memory handshake and tells each pipeline stage when to stall.

## Interface
Parameters:
- `LAT`, default 4: memory access latency in cycles. Legal range is 1..15.
- `AW`, default 16: address width.
- `DW`, default 16: data width.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch read request; held high until `i_done`.
- `i_addr`  in  AW  fetch address.
- `i_rdata`  out  DW  fetch read data, valid while `i_done` is high.
- `i_done`  out  1  one-cycle fetch completion pulse.
- `i_stall`  out  1  `i_req & ~i_done`; combinational.
- `d_req`  in  1  data request; held high until `d_done`.
- `d_wr`  in  1  1 = write, 0 = read.
- `d_addr`  in  AW  data address.
- `d_wdata`  in  DW  write data.
- `d_rdata`  out  DW  data read data, valid while `d_done` is high.
- `d_done`  out  1  one-cycle data completion pulse.
- `d_stall`  out  1  `d_req & ~d_done`; combinational.
- `mem_en`  out  1  one-cycle memory start strobe.
- `mem_wr`  out  1  write qualifier, valid while `mem_en` is high.
- `mem_addr`  out  AW  latched address.
- `mem_wdata`  out  DW  latched write data.
- `mem_rdata`  in  DW  memory read data, valid exactly LAT cycles after the `mem_en` edge.
- `err`  out  1  sticky: an odd address was granted.

## Operation
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - If any request is high, grant it, latch the request's addr/wdata/wr and owner, set `mem_en` to 1 (registered), load the counter with LAT-1, and go to BUSY.
  - If both requests are high, arbitration follows the Configuration section.
- BUSY:
  - `mem_en` is 0 after its first cycle.
  - If the counter is non-zero, decrement it.
  - If the counter is 0, register `mem_rdata` into the owner's rdata output, set the owner's done to 1, and go to RESP.
- RESP:
  - The owner's done is high for exactly this cycle.
  - All requests are ignored, so a requester still holding req this cycle is not re-granted.
  - Go to IDLE.
- Writes:
  - The done pulse is issued with the same timing as reads.
  - The rdata output is left unchanged.
- Requests that change during BUSY or RESP have no effect; the latched copy is used.
- Odd address: bit 0 is forced to 0 on `mem_addr`, `err` is set to 1 and stays set until reset, and the transaction still completes.
- Reset (any time, including mid-transaction):
  - All outputs go to 0 immediately and the state goes to IDLE.
  - The outstanding transaction is abandoned and no done pulse is issued.

## Timing
- Grant edge k → `mem_en` high during cycle k+1.
- Done is high in the cycle after edge k+LAT.
- A transaction occupies LAT+2 cycles in total, IDLE grant cycle included.
- Minimum spacing between grants is LAT+2 cycles.
- `i_stall`/`d_stall` are high from the first req cycle through the last cycle before done.
- Reset values: every registered output is 0, and `err` is 0.

## Configuration
- Macro `MEM_ARB_ROUND_ROBIN_EN`.
- Defined:
  - A `last_owner` flop is kept.
  - On a simultaneous request, the port not served last wins.
  - `last_owner` resets to I, so D wins the first tie.
- Undefined: D always wins ties. This is fixed priority; the older instruction goes first, so there is no deadlock.

## Structure
- Package `mem_arb_pkg`:
  - state enum (IDLE/BUSY/RESP);
  - owner enum (OWN_I/OWN_D);
  - counter width constant `CNT_W = 4`.
- Sub-module `arb_lat_cnt`: a loadable down-counter with a zero flag. It has load/dec inputs and resets asynchronously to 0.
- The arbiter holds the FSM, the request latches and the output registers.

## Test plan
- Isolated fetch, LAT=4: `i_req`, `i_addr`=0x0010, memory returns 0xBEEF → `mem_en` high 1 cycle after grant, `i_done` high 5 cycles after grant with `i_rdata`=0xBEEF, `i_stall` low in the following cycle.
- Simultaneous `i_req`/`d_req` read (0x0020 → 0x1234) without the macro → D served first and I served next, with grants 6 cycles apart; with the macro and two back-to-back ties, the order is D then I.
- Data write `d_addr`=0x0040, `d_wdata`=0x5A5A → `mem_wr`=1 with `mem_en`, `d_done` pulses, `d_rdata` unchanged.
- Requester holds `i_req` through RESP → no second grant in RESP; a fresh grant occurs in the next IDLE cycle.
- `d_addr`=0x0007 → `mem_addr`=0x0006, `err`=1 and stays 1 across later transactions until reset.
- Reset asserted in BUSY with the counter at 2 → all outputs 0 that cycle, no done pulse; after release a new `i_req` completes normally. Repeat with LAT=1: done comes 2 cycles after grant.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, port owner
// encoding and the width of the latency counter.
package mem_arb_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_lat_cnt.sv
// Loadable down-counter with a zero flag. It tracks how many cycles remain
// before the memory read data becomes valid.
module arb_lat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch I / data D) arbiter and sequencer for one shared
// fixed-latency memory. Optional round-robin tie breaking is enabled with
// the macro MEM_ARB_ROUND_ROBIN_EN; otherwise D always wins a tie.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LAT = 4,
    parameter int AW  = 16,
    parameter int DW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    output logic          i_stall,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          d_stall,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          err
);

    state_t        state;
    owner_t        owner;
    logic          pick_d;
    logic          grant;
    logic          cnt_zero;
    logic [AW-1:0] sel_addr;

    assign grant = (state == IDLE) && (i_req || d_req);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t last_owner;

    // On a tie, the port that was not served last goes first.
    assign pick_d = d_req && (!i_req || last_owner == OWN_I);

    // Remember the most recent winner to alternate on ties.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_owner <= OWN_I;
        else if (grant)
            last_owner <= pick_d ? OWN_D : OWN_I;
    end
`else
    // Fixed priority: the memory stage holds the older instruction.
    assign pick_d = d_req;
`endif

    // Address of whichever port wins this cycle.
    always_comb begin
        sel_addr = pick_d ? d_addr : i_addr;
    end

    arb_lat_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (grant),
        .dec      (state == BUSY),
        .load_val (CNT_W'(LAT - 1)),
        .zero     (cnt_zero)
    );

    // Sequencer FSM: grant in IDLE, wait LAT cycles in BUSY, pulse done in RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_I;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner     <= pick_d ? OWN_D : OWN_I;
                        mem_en    <= 1'b1;
                        mem_wr    <= pick_d && d_wr;
                        mem_addr  <= {sel_addr[AW-1:1], 1'b0};
                        mem_wdata <= pick_d ? d_wdata : '0;
                        if (sel_addr[0])
                            err <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_zero) begin
                        if (owner == OWN_D) begin
                            d_done <= 1'b1;
                            if (!mem_wr)
                                d_rdata <= mem_rdata;
                        end else begin
                            i_done  <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                        state <= RESP;
                    end
                end
                // Requests are ignored here so a held req is not re-granted.
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign i_stall = i_req && !i_done;
    assign d_stall = d_req && !d_done;

endmodule
